// File: rtl/corelet_pkg.sv
// Shared definitions for the corelet sequencer: FSM states, instruction-word
// bit positions and the fixed SRAM base addresses.
package corelet_pkg;

    localparam int INST_W = 34;

    localparam int B_KLOAD    = 0;
    localparam int B_EXEC     = 1;
    localparam int B_L0_WR    = 2;
    localparam int B_L0_RD    = 3;
    localparam int B_XMEM_RD  = 4;
    localparam int B_PSUM_RD  = 5;
    localparam int B_OFIFO_RD = 6;
    localparam int B_XADDR_LO = 7;
    localparam int B_PADDR_LO = 18;
    localparam int B_PSUM_WR  = 29;
    localparam int B_OUT_WR   = 30;
    localparam int B_SFP_ACC  = 33;

    // Weights occupy xmem [0, 72), activations start at 256; outputs land at 512
    localparam int W_BASE = 0;
    localparam int X_BASE = 256;
    localparam int O_BASE = 512;

    typedef enum logic [3:0] {
        S_IDLE,
        S_W_LOAD,
        S_W_SHIFT,
        S_W_FLUSH,
        S_X_LOAD,
        S_X_EXEC,
        S_DRAIN,
        S_ACC,
        S_DONE
    } state_t;

endpackage

// File: rtl/conv_addr_gen.sv
// Nested kx/ky (inner) and ox/oy (outer) counters that walk the psum SRAM
// for the accumulation phase, plus the matching output pixel index.
module conv_addr_gen
    import corelet_pkg::*;
#(
    parameter int KSZ = 3,
    parameter int IW  = 6,
    parameter int AW  = 11
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          clear,
    input  logic          step_k,
    input  logic          step_o,
    output logic [AW-1:0] psum_addr,
    output logic [AW-1:0] onij,
    output logic          last_k,
    output logic          last_o
);

    localparam int OW      = IW - KSZ + 1;
    localparam int LEN_NIJ = IW * IW;
    localparam int KCW     = $clog2(KSZ + 1);
    localparam int OCW     = $clog2(OW + 1);

    localparam logic [KCW-1:0] K_LAST = KCW'(KSZ - 1);
    localparam logic [OCW-1:0] O_LAST = OCW'(OW - 1);

    logic [KCW-1:0] kx, ky;
    logic [OCW-1:0] ox, oy;
    logic [AW-1:0]  kij;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples its inputs from before the edge, independent of statement order.
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            kx <= '0;
            ky <= '0;
            ox <= '0;
            oy <= '0;
        end else begin
            if (step_k) begin
                if (kx == K_LAST) begin
                    kx <= '0;
                    ky <= (ky == K_LAST) ? '0 : ky + KCW'(1);
                end else begin
                    kx <= kx + KCW'(1);
                end
            end
            if (step_o) begin
                if (ox == O_LAST) begin
                    ox <= '0;
                    oy <= (oy == O_LAST) ? '0 : oy + OCW'(1);
                end else begin
                    ox <= ox + OCW'(1);
                end
            end
        end
    end

    // Each kernel position kij has its own len_nij-sized psum plane
    assign kij       = AW'(ky) * AW'(KSZ) + AW'(kx);
    assign psum_addr = kij * AW'(LEN_NIJ) + (AW'(oy) + AW'(ky)) * AW'(IW) + AW'(ox) + AW'(kx);
    assign onij      = AW'(oy) * AW'(OW) + AW'(ox);
    assign last_k    = (kx == K_LAST) && (ky == K_LAST);
    assign last_o    = (ox == O_LAST) && (oy == O_LAST);

endmodule

// File: rtl/corelet_ctrl.sv
// Tile sequencer: per kernel position loads weights, streams activations and
// drains psums, then accumulates all kernel positions per output pixel.
module corelet_ctrl
    import corelet_pkg::*;
#(
    parameter int ROW = 8,
    parameter int COL = 8,
    parameter int KSZ = 3,
    parameter int IW  = 6,
    parameter int AW  = 11
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              relu_cfg,
    input  logic              ofifo_valid,
    output logic [INST_W-1:0] inst,
    output logic              xw_mode,
    output logic              sfp_reset,
    output logic              relu_en,
    output logic              busy,
    output logic              done
);

    localparam int LEN_KIJ = KSZ * KSZ;
    localparam int LEN_NIJ = IW * IW;
    localparam int CW      = $clog2(LEN_NIJ + ROW + COL + 4);
    localparam int KW      = $clog2(LEN_KIJ + 1);

    localparam logic [CW-1:0] W_LAST   = CW'(COL - 1);
    localparam logic [CW-1:0] F_LAST   = CW'(ROW + COL - 1);
    localparam logic [CW-1:0] N_LAST   = CW'(LEN_NIJ - 1);
    localparam logic [KW-1:0] KIJ_LAST = KW'(LEN_KIJ - 1);

    // ACC sub-phases; the read phase holds until the address generator
    // reports the last kernel position
    localparam logic [CW-1:0] ACC_SFP  = CW'(0);
    localparam logic [CW-1:0] ACC_RD   = CW'(1);
    localparam logic [CW-1:0] ACC_TAIL = CW'(2);
    localparam logic [CW-1:0] ACC_WR   = CW'(3);

    state_t        state, state_next;
    logic [CW-1:0] cnt;
    logic [KW-1:0] kij;
    logic          l0_wr_d, acc_d;
    logic          xmem_rd, psum_rd;
    logic          drain_last, acc_wr;
    logic [AW-1:0] gen_addr, gen_onij;
    logic          gen_last_k, gen_last_o;

    assign drain_last = (state == S_DRAIN) && ofifo_valid && (cnt == N_LAST);
    assign acc_wr     = (state == S_ACC) && (cnt == ACC_WR);

    always_ff @(posedge clk) begin
        if (reset) state <= S_IDLE;
        else       state <= state_next;
    end

    // NOTE: every signal written in an always_comb gets a default first, so
    // no path can leave it unassigned and infer a latch.
    always_comb begin
        state_next = state;
        unique case (state)
            S_IDLE:    if (start)                 state_next = S_W_LOAD;
            S_W_LOAD:  if (cnt == W_LAST)         state_next = S_W_SHIFT;
            S_W_SHIFT: if (cnt == W_LAST)         state_next = S_W_FLUSH;
            S_W_FLUSH: if (cnt == F_LAST)         state_next = S_X_LOAD;
            S_X_LOAD:  if (cnt == N_LAST)         state_next = S_X_EXEC;
            S_X_EXEC:  if (cnt == N_LAST)         state_next = S_DRAIN;
            S_DRAIN:   if (drain_last)            state_next = (kij == KIJ_LAST) ? S_ACC : S_W_LOAD;
            S_ACC:     if (acc_wr && gen_last_o)  state_next = S_DONE;
            S_DONE:                               state_next = S_IDLE;
            default:                              state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt     <= '0;
            kij     <= '0;
            l0_wr_d <= 1'b0;
            acc_d   <= 1'b0;
            relu_en <= 1'b0;
        end else begin
            // Read data arrives one cycle later, so the dependent write follows
            l0_wr_d <= xmem_rd;
            acc_d   <= psum_rd;
            if (state == S_IDLE && start) relu_en <= relu_cfg;

            if (state_next != state || state == S_IDLE) begin
                cnt <= '0;
            end else if (state == S_ACC) begin
                if (cnt == ACC_WR)                     cnt <= '0;
                else if (cnt != ACC_RD || gen_last_k)  cnt <= cnt + CW'(1);
            end else if (state != S_DRAIN || ofifo_valid) begin
                cnt <= cnt + CW'(1);
            end

            if (drain_last) kij <= (kij == KIJ_LAST) ? '0 : kij + KW'(1);
        end
    end

    always_comb begin
        inst      = '0;
        xw_mode   = 1'b0;
        sfp_reset = reset;
        xmem_rd   = 1'b0;
        psum_rd   = 1'b0;
        unique case (state)
            S_W_LOAD: begin
                xmem_rd = 1'b1;
                inst[B_XADDR_LO +: AW] = AW'(W_BASE) + AW'(kij) * AW'(COL) + AW'(cnt);
            end
            S_W_SHIFT: begin
                inst[B_L0_RD] = 1'b1;
                inst[B_KLOAD] = 1'b1;
            end
            S_X_LOAD: begin
                xmem_rd = 1'b1;
                xw_mode = 1'b1;
                inst[B_XADDR_LO +: AW] = AW'(X_BASE) + AW'(cnt);
            end
            S_X_EXEC: begin
                xw_mode       = 1'b1;
                inst[B_L0_RD] = 1'b1;
                inst[B_EXEC]  = 1'b1;
            end
            S_DRAIN: begin
                // OFIFO is read-ahead: the head is written in the cycle it is popped
                if (ofifo_valid) begin
                    inst[B_OFIFO_RD] = 1'b1;
                    inst[B_PSUM_WR]  = 1'b1;
                    inst[B_PADDR_LO +: AW] = AW'(kij) * AW'(LEN_NIJ) + AW'(cnt);
                end
            end
            S_ACC: begin
                if (cnt == ACC_SFP) sfp_reset = 1'b1;
                if (cnt == ACC_RD) begin
                    psum_rd = 1'b1;
                    inst[B_PADDR_LO +: AW] = gen_addr;
                end
                if (cnt == ACC_WR) begin
                    inst[B_OUT_WR] = 1'b1;
                    inst[B_PADDR_LO +: AW] = AW'(O_BASE) + gen_onij;
                end
            end
            default: ;
        endcase
        inst[B_XMEM_RD] = xmem_rd;
        inst[B_PSUM_RD] = psum_rd;
        inst[B_L0_WR]   = l0_wr_d;
        inst[B_SFP_ACC] = acc_d;
        busy = (state != S_IDLE) && (state != S_DONE);
        done = (state == S_DONE);
    end

    conv_addr_gen #(
        .KSZ (KSZ),
        .IW  (IW),
        .AW  (AW)
    ) u_addr_gen (
        .clk       (clk),
        .reset     (reset),
        .clear     (state != S_ACC),
        .step_k    (psum_rd),
        .step_o    (acc_wr),
        .psum_addr (gen_addr),
        .onij      (gen_onij),
        .last_k    (gen_last_k),
        .last_o    (gen_last_o)
    );

endmodule

// File: tb/tb_corelet_ctrl.sv
// Directed bench for corelet_ctrl: one full tile cycle-by-cycle against
// hand-derived instruction words, then a mid-tile reset and restart.
module tb_corelet_ctrl;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        relu_cfg = 1'b0;
    logic        ofifo_valid = 1'b0;
    logic [33:0] inst;
    logic        xw_mode, sfp_reset, relu_en, busy, done;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    corelet_ctrl dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .relu_cfg    (relu_cfg),
        .ofifo_valid (ofifo_valid),
        .inst        (inst),
        .xw_mode     (xw_mode),
        .sfp_reset   (sfp_reset),
        .relu_en     (relu_en),
        .busy        (busy),
        .done        (done)
    );

    // Inputs change 1 ns after the edge; outputs are sampled 2 ns after it
    task automatic step(input logic r, input logic s, input logic v);
        @(posedge clk);
        #1;
        reset = r;
        start = s;
        ofifo_valid = v;
        #1;
    endtask

    task automatic test_reset();
        step(1, 0, 0);
        step(1, 0, 0);
        checks++;
        if ({inst, busy, done, xw_mode, relu_en} !== 38'd0) begin
            errors++;
            $display("FAIL reset_outputs inst=%h busy=%b done=%b xw=%b relu=%b want all 0", inst, busy, done, xw_mode, relu_en);
        end
        checks++;
        if (sfp_reset !== 1'b1) begin
            errors++;
            $display("FAIL reset_sfp sfp_reset=%b want 1", sfp_reset);
        end
        for (int i = 0; i < 5; i++) begin
            step(0, 0, 0);
            checks++;
            if ({inst, busy, sfp_reset, done} !== 37'd0) begin
                errors++;
                $display("FAIL idle[%0d] inst=%h busy=%b sfp=%b done=%b want 0", i, inst, busy, sfp_reset, done);
            end
        end
    endtask

    task automatic test_weight_load();
        logic [33:0] exp;
        relu_cfg = 1'b1;
        step(0, 1, 0);
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL start_edge_busy busy=%b want 0", busy);
        end
        for (int i = 0; i < 8; i++) begin
            step(0, 0, 0);
            relu_cfg = 1'b0;
            exp = '0;
            exp[4] = 1'b1;
            exp[17:7] = 11'(i);
            exp[2] = (i > 0);
            checks++;
            if (inst !== exp || busy !== 1'b1 || xw_mode !== 1'b0) begin
                errors++;
                $display("FAIL w_load[%0d] inst=%h busy=%b xw=%b want inst=%h busy=1 xw=0", i, inst, busy, xw_mode, exp);
            end
        end
        for (int j = 0; j < 8; j++) begin
            step(0, 0, 0);
            exp = 34'h9;
            exp[2] = (j == 0);
            checks++;
            if (inst !== exp || xw_mode !== 1'b0) begin
                errors++;
                $display("FAIL w_shift[%0d] inst=%h xw=%b want inst=%h xw=0", j, inst, xw_mode, exp);
            end
        end
    endtask

    // A start pulse in the middle of the flush must be ignored
    task automatic test_flush_start_ignored();
        for (int j = 0; j < 16; j++) begin
            step(0, (j == 3), 0);
            checks++;
            if (inst !== 34'd0 || busy !== 1'b1) begin
                errors++;
                $display("FAIL w_flush[%0d] inst=%h busy=%b want inst=0 busy=1", j, inst, busy);
            end
        end
    endtask

    task automatic test_act_stream();
        logic [33:0] exp;
        for (int n = 0; n < 36; n++) begin
            step(0, 0, 0);
            exp = '0;
            exp[4] = 1'b1;
            exp[17:7] = 11'(256 + n);
            exp[2] = (n > 0);
            checks++;
            if (inst !== exp || xw_mode !== 1'b1) begin
                errors++;
                $display("FAIL x_load[%0d] inst=%h xw=%b want inst=%h xw=1", n, inst, xw_mode, exp);
            end
        end
        for (int n = 0; n < 36; n++) begin
            step(0, 0, 0);
            exp = 34'ha;
            exp[2] = (n == 0);
            checks++;
            if (inst !== exp || xw_mode !== 1'b1) begin
                errors++;
                $display("FAIL x_exec[%0d] inst=%h xw=%b want inst=%h xw=1", n, inst, xw_mode, exp);
            end
        end
    endtask

    task automatic test_drain_stall();
        logic [33:0] exp;
        int n = 0;
        int c = 0;
        while (n < 36 && c < 100) begin
            step(0, 0, (c % 2 == 0));
            exp = '0;
            if (c % 2 == 0) begin
                exp[6] = 1'b1;
                exp[29] = 1'b1;
                exp[28:18] = 11'(n);
                n++;
            end
            checks++;
            if (inst !== exp) begin
                errors++;
                $display("FAIL drain[c=%0d] inst=%h want %h", c, inst, exp);
            end
            c++;
        end
        // After exactly 36 writes the next kernel position's weight load begins
        step(0, 0, 0);
        exp = '0;
        exp[4] = 1'b1;
        exp[17:7] = 11'd8;
        checks++;
        if (inst !== exp) begin
            errors++;
            $display("FAIL kij1_w_load inst=%h want %h", inst, exp);
        end
    endtask

    // Remaining kernel positions with an always-valid OFIFO: psum writes of
    // kij=1..8 cover addresses 36..323 in order
    task automatic test_remaining_kij();
        int wr_idx = 0;
        for (int i = 0; i < 1119; i++) begin
            step(0, 0, 1);
            if (inst[29] === 1'b1) begin
                checks++;
                if (inst[28:18] !== 11'(36 + wr_idx)) begin
                    errors++;
                    $display("FAIL bulk_wr[%0d] addr=%0d want %0d", wr_idx, inst[28:18], 36 + wr_idx);
                end
                wr_idx++;
            end
        end
        checks++;
        if (wr_idx != 288) begin
            errors++;
            $display("FAIL bulk_wr_count got=%0d want 288", wr_idx);
        end
    endtask

    task automatic test_accumulate();
        logic [33:0] exp;
        int acc5 [9] = '{7, 8, 9, 13, 14, 15, 19, 20, 21};
        int outs = 0;
        int onij, p, oy, ox, k;
        for (int c = 0; c < 192; c++) begin
            step(0, 0, 0);
            onij = c / 12;
            p = c % 12;
            oy = onij / 4;
            ox = onij % 4;
            exp = '0;
            if (p >= 1 && p <= 9) begin
                k = p - 1;
                exp[5] = 1'b1;
                exp[28:18] = 11'(k * 36 + (oy + k / 3) * 6 + ox + k % 3);
            end
            if (p >= 2 && p <= 10) exp[33] = 1'b1;
            if (p == 11) begin
                exp[30] = 1'b1;
                exp[28:18] = 11'(512 + onij);
            end
            checks++;
            if (inst !== exp || sfp_reset !== (p == 0) || busy !== 1'b1 || done !== 1'b0) begin
                errors++;
                $display("FAIL acc[onij=%0d p=%0d] inst=%h sfp=%b busy=%b done=%b want inst=%h sfp=%b busy=1 done=0",
                         onij, p, inst, sfp_reset, busy, done, exp, (p == 0));
            end
            if (onij == 5 && p >= 1 && p <= 9) begin
                checks++;
                if (inst[28:18] !== 11'(acc5[p-1] + (p - 1) * 36)) begin
                    errors++;
                    $display("FAIL acc5_rd[%0d] addr=%0d want %0d", p - 1, inst[28:18], acc5[p-1] + (p - 1) * 36);
                end
            end
            if (inst[30] === 1'b1) outs++;
        end
        checks++;
        if (outs != 16) begin
            errors++;
            $display("FAIL out_wr_count got=%0d want 16", outs);
        end
    endtask

    task automatic test_done();
        step(0, 0, 0);
        checks++;
        if (done !== 1'b1 || busy !== 1'b0 || inst !== 34'd0 || relu_en !== 1'b1) begin
            errors++;
            $display("FAIL done_cycle done=%b busy=%b inst=%h relu=%b want done=1 busy=0 inst=0 relu=1", done, busy, inst, relu_en);
        end
        step(0, 0, 0);
        checks++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL after_done done=%b busy=%b want 0 0", done, busy);
        end
    endtask

    task automatic test_reset_mid_tile();
        relu_cfg = 1'b1;
        step(0, 1, 0);
        for (int i = 0; i < 70; i++) step(0, 0, 0);
        checks++;
        if (inst !== 34'ha) begin
            errors++;
            $display("FAIL mid_x_exec inst=%h want 00000000a", inst);
        end
        step(1, 0, 0);
        checks++;
        if (sfp_reset !== 1'b1) begin
            errors++;
            $display("FAIL mid_reset_sfp sfp=%b want 1", sfp_reset);
        end
        step(0, 0, 0);
        checks++;
        if (inst !== 34'd0 || busy !== 1'b0 || relu_en !== 1'b0 || xw_mode !== 1'b0) begin
            errors++;
            $display("FAIL post_reset inst=%h busy=%b relu=%b xw=%b want all 0", inst, busy, relu_en, xw_mode);
        end
        for (int i = 0; i < 3; i++) begin
            step(0, 0, 0);
            checks++;
            if (done !== 1'b0 || busy !== 1'b0) begin
                errors++;
                $display("FAIL post_reset_idle[%0d] done=%b busy=%b want 0 0", i, done, busy);
            end
        end
        relu_cfg = 1'b0;
        step(0, 1, 0);
        step(0, 0, 0);
        checks++;
        if (inst !== 34'h10 || busy !== 1'b1 || relu_en !== 1'b0) begin
            errors++;
            $display("FAIL restart_w0 inst=%h busy=%b relu=%b want inst=10 busy=1 relu=0", inst, busy, relu_en);
        end
        step(0, 0, 0);
        checks++;
        if (inst !== 34'h94) begin
            errors++;
            $display("FAIL restart_w1 inst=%h want 94", inst);
        end
    endtask

    initial begin
        test_reset();
        test_weight_load();
        test_flush_start_ignored();
        test_act_stream();
        test_drain_stall();
        test_remaining_kij();
        test_accumulate();
        test_done();
        test_reset_mid_tile();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
